xorshift_multi: RTL and testbench
=================================

# xorshift_multi

Parametrised, multi-lane xorshift pseudo-random generator and the next generation of the single-lane 32-bit xorshift block. It produces LANES independent WIDTH-bit streams per step, and each lane's shift triple and direction are set by parameters. It adds a valid/ready output handshake, a post-reseed warm-up phase, and zero-seed protection. It sits beside the Tausworthe and xorshift RNGs in the stochastic-computing datapath and feeds consumers that can stall.

## Interface
- WIDTH, 32: state/output width per lane; legal values 32 or 64.
- LANES, 4: number of parallel streams, 1..16.
- A, 13: first shift amount, 1..WIDTH-1.
- B, 17: second shift amount, 1..WIDTH-1.
- C, 5: third shift amount, 1..WIDTH-1.
- LEFT_A, 1: direction of the first shift (1 = left, 0 = right).
- LEFT_B, 0: direction of the second shift (1 = left, 0 = right).
- LEFT_C, 1: direction of the third shift (1 = left, 0 = right).
- WARMUP, 8: steps discarded after every reseed, 0..255.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- seed  in  WIDTH  base seed, sampled only when re_seed=1.
- re_seed  in  1  active-high reseed request; wins over all other activity.
- out_ready  in  1  consumer accepts the current word.
- out_valid  out  1  rnd holds a valid post-warm-up word.
- rnd  out  LANES*WIDTH  current lane states; lane i occupies bits [i*WIDTH +: WIDTH].
- busy  out  1  high during warm-up.

## Operation
- Step function, applied per lane: s1 = s ^ (s shA A), s2 = s1 ^ (s1 shB B), s3 = s2 ^ (s2 shC C).
  - Each shift direction comes from its LEFT_x parameter.
  - Results are truncated to WIDTH bits.
- Lane seed derivation: d_i = seed ^ (i * LANE_SALT), computed mod 2^WIDTH.
  - If d_i == 0, DEFAULT_SEED is loaded instead.
  - A lane state is therefore never zero.
- rnd always shows the current state registers. The combinational next state is never exposed.
- FSM has two states:
  - WARM: every cycle all lanes advance and the counter decrements. When the counter reaches 0, the FSM moves to RUN.
  - RUN: out_valid=1. Lanes advance only when out_valid && out_ready.
- Reseed (re_seed=1, any state):
  - Next cycle, lanes hold d_i and the counter holds WARMUP.
  - State goes to WARM if WARMUP>0, otherwise RUN.
  - No advance happens in the reseed cycle.
- Reset values:
  - Lanes = derivation with seed=0, so lane 0 = DEFAULT_SEED and lane i = i*LANE_SALT.
  - Counter = WARMUP; state = WARM, or RUN if WARMUP=0.
  - busy = (WARMUP>0).
  - out_valid = (WARMUP=0).
- Back-pressure: while out_valid && !out_ready, rnd and all state are held stable.

## Timing
- Reseed latency:
  - re_seed sampled at edge E0.
  - After E0, rnd = d_i and busy=1.
  - Edges E1..E_WARMUP advance the lanes.
  - After E_WARMUP, out_valid=1 and rnd = step^WARMUP(d_i).
- With WARMUP=0, out_valid is high immediately after E0 and rnd = d_i.
- Throughput in RUN: one LANES-wide word per cycle while out_ready=1.
- out_valid and busy are registered and mutually exclusive. busy == (state==WARM).
- Reset asserted mid-run: all registers take their reset values immediately (asynchronous).
- A reseed during WARM restarts the count from WARMUP.

## Structure
- Shared header xorshift_pkg.vh holds:
  - DEFAULT_SEED_32 = 32'h2545F491 and DEFAULT_SEED_64 = 64'h2545F4914F6CDD1D.
  - LANE_SALT_32 = 32'h9E3779B9 and LANE_SALT_64 = 64'h9E3779B97F4A7C15.
  - The FSM state encodings.
- Sub-module xorshift_step (parameters WIDTH, A, B, C, LEFT_*; purely combinational) is instantiated once per lane in a generate loop.
- Lane and control registers use the common Register module.

## Test plan
- Known vector: WIDTH=32, LANES=1, default shifts, WARMUP=0, seed=1, out_ready=1 → rnd = 0x00000001, then 0x00042021, then 0x04080601.
- Warm-up: WARMUP=2, seed=1 → busy=1 for 2 cycles with out_valid=0, then out_valid=1 with rnd=0x04080601.
- Back-pressure: in RUN, hold out_ready=0 for 5 cycles → rnd stays constant. On release, the next word equals the single-step successor.
- Zero seed: LANES=2, seed=0 → lane 0 = 0x2545F491 and lane 1 = 0x9E3779B9. No lane ever reads 0 across 1000 steps.
- Reseed mid-warm-up, then asynchronous reset: re_seed pulses at warm-up cycle 1 → the count restarts and out_valid rises exactly WARMUP cycles after the pulse edge. Dropping rst_n mid-RUN forces the reset values without waiting for a clock edge.
- WIDTH=64, LANES=4: compare every lane against a software model for 10000 accepted words with random out_ready.

Source files
------------

// File: rtl/xorshift_multi_pkg.sv
// Shared constants and FSM encoding for the multi-lane xorshift generator.
package xorshift_multi_pkg;

  localparam logic [31:0] DEFAULT_SEED_32 = 32'h2545F491;
  localparam logic [63:0] DEFAULT_SEED_64 = 64'h2545F4914F6CDD1D;
  localparam logic [31:0] LANE_SALT_32    = 32'h9E3779B9;
  localparam logic [63:0] LANE_SALT_64    = 64'h9E3779B97F4A7C15;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/xorshift_multi_step.sv
// One combinational xorshift step: three xor-with-shifted-self stages.
module xorshift_multi_step #(
  parameter int WIDTH  = 32,
  parameter int A      = 13,
  parameter int B      = 17,
  parameter int C      = 5,
  parameter bit LEFT_A = 1'b1,
  parameter bit LEFT_B = 1'b0,
  parameter bit LEFT_C = 1'b1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  assign s1  = LEFT_A ? (cur ^ (cur << A)) : (cur ^ (cur >> A));
  assign s2  = LEFT_B ? (s1 ^ (s1 << B)) : (s1 ^ (s1 >> B));
  assign nxt = LEFT_C ? (s2 ^ (s2 << C)) : (s2 ^ (s2 >> C));

endmodule

// File: rtl/xorshift_multi.sv
// LANES parallel xorshift streams with reseed, warm-up discard and a valid/ready output.
module xorshift_multi
  import xorshift_multi_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int A      = 13,
  parameter int B      = 17,
  parameter int C      = 5,
  parameter bit LEFT_A = 1'b1,
  parameter bit LEFT_B = 1'b0,
  parameter bit LEFT_C = 1'b1,
  parameter int WARMUP = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   re_seed,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] rnd,
  output logic                   busy
);

  localparam logic [63:0] DEF_SEL  = (WIDTH == 64) ? DEFAULT_SEED_64 : {32'h0, DEFAULT_SEED_32};
  localparam logic [63:0] SALT_SEL = (WIDTH == 64) ? LANE_SALT_64 : {32'h0, LANE_SALT_32};
  localparam logic [WIDTH-1:0] DEF_SEED = DEF_SEL[WIDTH-1:0];
  localparam logic [7:0] WARM_CNT = 8'(WARMUP);
  localparam bit NO_WARM = (WARMUP == 0);

  state_t     state;
  logic [7:0] cnt;
  logic       advance;

  // Warm-up steps free-run; in RUN only an accepted word moves the lanes.
  assign advance = (state == ST_WARM) || (out_valid && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NO_WARM ? ST_RUN : ST_WARM;
      cnt       <= WARM_CNT;
      out_valid <= NO_WARM;
      busy      <= !NO_WARM;
    end else if (re_seed) begin
      state     <= NO_WARM ? ST_RUN : ST_WARM;
      cnt       <= WARM_CNT;
      out_valid <= NO_WARM;
      busy      <= !NO_WARM;
    end else begin
      case (state)
        ST_WARM: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state     <= ST_RUN;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [63:0] LANE_MUL = 64'(i) * SALT_SEL;
    localparam logic [WIDTH-1:0] LANE_OFS = LANE_MUL[WIDTH-1:0];
    // Seed 0 derivation; only lane 0 can land on zero here.
    localparam logic [WIDTH-1:0] RST_VAL = (LANE_OFS == '0) ? DEF_SEED : LANE_OFS;

    logic [WIDTH-1:0] lane_q;
    logic [WIDTH-1:0] lane_nxt;
    logic [WIDTH-1:0] derived;
    logic [WIDTH-1:0] salted;

    assign salted  = seed ^ LANE_OFS;
    assign derived = (salted == '0) ? DEF_SEED : salted;

    xorshift_multi_step #(
      .WIDTH (WIDTH),
      .A     (A),
      .B     (B),
      .C     (C),
      .LEFT_A(LEFT_A),
      .LEFT_B(LEFT_B),
      .LEFT_C(LEFT_C)
    ) u_step (
      .cur(lane_q),
      .nxt(lane_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= RST_VAL;
      end else if (re_seed) begin
        lane_q <= derived;
      end else if (advance) begin
        lane_q <= lane_nxt;
      end
    end

    assign rnd[i*WIDTH +: WIDTH] = lane_q;
  end

endmodule

// File: tb/tb_xorshift_multi.sv
// Directed checks of xorshift_multi in three configurations plus a 64-bit model comparison.
module tb_xorshift_multi;

  localparam logic [63:0] DEF32  = 64'h2545F491;
  localparam logic [63:0] SALT32 = 64'h9E3779B9;
  localparam logic [63:0] DEF64  = 64'h2545F4914F6CDD1D;
  localparam logic [63:0] SALT64 = 64'h9E3779B97F4A7C15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: 32-bit, 1 lane, no warm-up
  logic [31:0] seed0 = '0;
  logic        rs0 = 1'b0, rdy0 = 1'b0, ov0, busy0;
  logic [31:0] rnd0;
  // dut1: 32-bit, 2 lanes, warm-up 2
  logic [31:0] seed1 = '0;
  logic        rs1 = 1'b0, rdy1 = 1'b0, ov1, busy1;
  logic [63:0] rnd1;
  // dut2: 64-bit, 4 lanes, no warm-up
  logic [63:0]  seed2 = '0;
  logic         rs2 = 1'b0, rdy2 = 1'b0, ov2, busy2;
  logic [255:0] rnd2;

  xorshift_multi #(.WIDTH(32), .LANES(1), .WARMUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed(seed0), .re_seed(rs0), .out_ready(rdy0),
    .out_valid(ov0), .rnd(rnd0), .busy(busy0));
  xorshift_multi #(.WIDTH(32), .LANES(2), .WARMUP(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed(seed1), .re_seed(rs1), .out_ready(rdy1),
    .out_valid(ov1), .rnd(rnd1), .busy(busy1));
  xorshift_multi #(.WIDTH(64), .LANES(4), .WARMUP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed(seed2), .re_seed(rs2), .out_ready(rdy2),
    .out_valid(ov2), .rnd(rnd2), .busy(busy2));

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] s, input int w);
    logic [63:0] m, s1, s2, s3;
    m  = (w == 64) ? '1 : 64'hFFFF_FFFF;
    s1 = (s ^ (s << 13)) & m;
    s2 = (s1 ^ (s1 >> 17)) & m;
    s3 = (s2 ^ (s2 << 5)) & m;
    return s3;
  endfunction

  logic [63:0] mdl[4];
  logic [63:0] d;
  logic        zero_seen;
  logic        acc;
  int          accepted;

  initial begin
    @(negedge clk);
    check("rst0_valid", 64'(ov0), 64'd1);
    check("rst0_busy", 64'(busy0), 64'd0);
    check("rst0_lane0", 64'(rnd0), DEF32);
    check("rst1_valid", 64'(ov1), 64'd0);
    check("rst1_busy", 64'(busy1), 64'd1);
    check("rst1_lane0", 64'(rnd1[31:0]), DEF32);
    check("rst1_lane1", 64'(rnd1[63:32]), SALT32);
    check("rst2_lane0", rnd2[63:0], DEF64);
    check("rst2_lane1", rnd2[127:64], SALT64);
    rst_n = 1'b1;

    // Known vector, no warm-up
    seed0 = 32'd1; rs0 = 1'b1; rdy0 = 1'b1;
    @(negedge clk); rs0 = 1'b0;
    check("kv_valid", 64'(ov0), 64'd1);
    check("kv_w0", 64'(rnd0), 64'h00000001);
    @(negedge clk);
    check("kv_w1", 64'(rnd0), 64'h00042021);
    @(negedge clk);
    check("kv_w2", 64'(rnd0), 64'h04080601);
    rdy0 = 1'b0;

    // Warm-up of 2 steps
    seed1 = 32'd1; rs1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk); rs1 = 1'b0;
    check("wu0_busy", 64'(busy1), 64'd1);
    check("wu0_valid", 64'(ov1), 64'd0);
    check("wu0_lane0", 64'(rnd1[31:0]), 64'h1);
    check("wu0_lane1", 64'(rnd1[63:32]), 64'h9E3779B8);
    @(negedge clk);
    check("wu1_busy", 64'(busy1), 64'd1);
    check("wu1_valid", 64'(ov1), 64'd0);
    @(negedge clk);
    check("wu2_busy", 64'(busy1), 64'd0);
    check("wu2_valid", 64'(ov1), 64'd1);
    check("wu2_lane0", 64'(rnd1[31:0]), 64'h04080601);
    check("wu2_lane1", 64'(rnd1[63:32]), ref_step(ref_step(64'h9E3779B8, 32), 32));

    // Back-pressure
    rdy1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 64'(rnd1[31:0]), 64'h04080601);
    end
    rdy1 = 1'b1;
    @(negedge clk);
    check("bp_release", 64'(rnd1[31:0]), ref_step(64'h04080601, 32));
    rdy1 = 1'b0;

    // Reseed during warm-up restarts the count
    seed1 = 32'd1; rs1 = 1'b1;
    @(negedge clk); rs1 = 1'b0;
    @(negedge clk);
    check("rsw_mid", 64'(rnd1[31:0]), 64'h00042021);
    rs1 = 1'b1;
    @(negedge clk); rs1 = 1'b0;
    check("rsw_e0_lane0", 64'(rnd1[31:0]), 64'h1);
    check("rsw_e0_busy", 64'(busy1), 64'd1);
    @(negedge clk);
    check("rsw_e1_valid", 64'(ov1), 64'd0);
    check("rsw_e1_busy", 64'(busy1), 64'd1);
    @(negedge clk);
    check("rsw_e2_valid", 64'(ov1), 64'd1);
    check("rsw_e2_lane0", 64'(rnd1[31:0]), 64'h04080601);

    // Asynchronous reset mid-RUN, between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(ov1), 64'd0);
    check("ar_busy", 64'(busy1), 64'd1);
    check("ar_lane0", 64'(rnd1[31:0]), DEF32);
    check("ar_lane1", 64'(rnd1[63:32]), SALT32);
    check("ar_dut0", 64'(rnd0), DEF32);
    @(negedge clk); rst_n = 1'b1;

    // Zero seed protection and no zero state over 1000 steps
    seed1 = 32'd0; rs1 = 1'b1; rdy1 = 1'b1;
    @(negedge clk); rs1 = 1'b0;
    check("zs_lane0", 64'(rnd1[31:0]), DEF32);
    check("zs_lane1", 64'(rnd1[63:32]), SALT32);
    zero_seen = 1'b0;
    for (int k = 0; k < 1002; k++) begin
      @(negedge clk);
      if (rnd1[31:0] == 32'd0 || rnd1[63:32] == 32'd0) zero_seen = 1'b1;
    end
    check("zs_nonzero", 64'(zero_seen), 64'd0);
    rdy1 = 1'b0;

    // 64-bit, 4 lanes: lane 2 derives to zero and must take the default seed
    seed2 = 64'h3C6EF372FE94F82A; rs2 = 1'b1;
    @(negedge clk); rs2 = 1'b0;
    check("w64_lane2_def", rnd2[191:128], DEF64);
    for (int i = 0; i < 4; i++) begin
      d = seed2 ^ (64'(i) * SALT64);
      mdl[i] = (d == 64'd0) ? DEF64 : d;
      check("w64_seed", rnd2[i*64 +: 64], mdl[i]);
    end
    accepted = 0;
    for (int cyc = 0; cyc < 30000 && accepted < 10000; cyc++) begin
      rdy2 = 1'($urandom_range(0, 1));
      acc  = rdy2 && ov2;
      @(negedge clk);
      if (acc) begin
        accepted++;
        for (int i = 0; i < 4; i++) begin
          mdl[i] = ref_step(mdl[i], 64);
          check("w64_lane", rnd2[i*64 +: 64], mdl[i]);
        end
      end else begin
        check("w64_hold", rnd2[63:0], mdl[0]);
      end
    end
    check("w64_accepted", 64'(accepted), 64'd10000);
    rdy2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
